datamem_ctrl: RTL
=================

DATAMEM_CTRL -- requirements
Module: datamem_ctrl

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have req, input, 1, single-cycle transaction request; issued only while busy=0.
REQ-004 SHALL have we, input, 1, 1=store, 0=load; sampled with req.
REQ-005 SHALL have addr, input, 32, byte address; sampled with req.
REQ-006 SHALL have func3, input, 3, RV32I load/store width code; sampled with req.
REQ-007 SHALL have wdata, input, 32, store data in the low bits; sampled with req.
REQ-008 SHALL have busy, output, 1, high when the FSM is not in IDLE.
REQ-009 SHALL have done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have err, output, 1, valid with done; misaligned access or illegal func3.
REQ-011 SHALL have rdata, output, 32, extended load result; valid with done.
REQ-012 SHALL have mem_we, output, 1, word-memory write enable.
REQ-013 SHALL have mem_addr, output, 32, word-memory byte address.
REQ-014 SHALL have mem_wdata, output, 32, word-memory write data.
REQ-015 SHALL have mem_rdata, input, 32, word-memory registered read data, valid one cycle after the address.
REQ-016 SHALL have mem_ready, input, 1, word-memory data-valid flag.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WAIT, WRITE and RESP.
REQ-018 On the req edge in IDLE, SHALL latch we, addr, func3 and wdata; req outside IDLE SHALL be ignored with no side effects.
REQ-019 Legal load func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store func3: 000 SB, 001 SH, 010 SW.
REQ-020 Illegal func3, halfword with addr[0]=1, or word with addr[1:0]!=0 SHALL go IDLE->RESP with err=1, rdata=0 and no memory access.
REQ-021 Legal transition paths SHALL be: load IDLE->READ->WAIT->RESP; SW IDLE->WRITE->RESP; SB/SH IDLE->READ->WAIT->WRITE->RESP.
REQ-022 mem_addr SHALL be {latched addr[31:2], 2'b00} in READ, WAIT and WRITE, and 0 otherwise.
REQ-023 mem_we SHALL be 1 only in WRITE; mem_wdata SHALL be 0 outside WRITE.
REQ-024 WAIT SHALL hold while mem_ready=0; when mem_ready=1, SHALL capture mem_rdata and advance.
REQ-025 Load extraction SHALL select byte lane addr[1:0] or halfword lane addr[1] from the captured word; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-026 SB SHALL replace only byte lane addr[1:0] with wdata[7:0]; SH SHALL replace only halfword lane addr[1] with wdata[15:0]; other bytes SHALL keep the captured word.
REQ-027 SW SHALL write wdata unmodified.
REQ-028 In RESP, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 err and rdata SHALL be registered and hold until the next accept; stores SHALL report rdata=0.
REQ-030 done SHALL occur this many cycles after the accept edge (mem_ready=1 throughout): error 1, SW 2, load 3, SB/SH 4.
REQ-031 A new req SHALL be accepted in the cycle after done (back-to-back operation).

Reset
REQ-032 reset SHALL asynchronously force IDLE and clear busy, done, err, rdata, mem_we, mem_addr, mem_wdata and all latched fields to 0.
REQ-033 reset mid-transaction SHALL abandon it: no mem_we pulse and no done pulse after reset.
REQ-034 The first req SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-035 SW 0x10 with 0xDEADBEEF, then LW 0x10 -> one mem_we pulse; done at +2 then +3 cycles; rdata=0xDEADBEEF; err=0.
REQ-036 Word 0x14=0x11223344; SB 0x17 with 0x000000AA -> word=0xAA223344; LB 0x17 -> 0xFFFFFFAA; LBU 0x17 -> 0x000000AA.
REQ-037 Word 0x18=0x11223344; SH 0x1A with 0x00008001 -> word=0x80013344; LH 0x1A -> 0xFFFF8001; LHU 0x1A -> 0x00008001.
REQ-038 LW 0x06, SH 0x05, or load with func3=011 -> done at +1 with err=1, rdata=0, and mem_we=0 throughout.
REQ-039 mem_ready held 0 for 3 cycles in WAIT during LW -> done delayed by 3 cycles; rdata correct.
REQ-040 reset asserted in WAIT of an SB -> busy=0 immediately, no mem_we, target word unchanged, next req serviced normally.

Source files
------------

// File: rtl/datamem_ctrl_if.sv
// Load/store request bus between the core LSU and the data-memory controller.
// The master issues single-cycle requests; the slave answers with done/err/rdata.
interface datamem_ctrl_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [2:0]  func3;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, func3, wdata,
      input  busy, done, err, rdata
   );

   modport slave (
      input  req, we, addr, func3, wdata,
      output busy, done, err, rdata
   );
endinterface

// File: rtl/datamem_ctrl.sv
// RV32I data-memory controller: byte/half/word loads and stores on a
// word-wide memory, with read-modify-write for sub-word stores.
module datamem_ctrl (
   input  logic             clk,
   input  logic             reset,
   datamem_ctrl_if.slave    bus,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_RESP
   } state_t;

   state_t      state_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [2:0]  func3_q;
   logic [31:0] wdata_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        acc_ok;
   logic        acc_sw;

   // Width code must exist for the direction and the address must be
   // naturally aligned for that width.
   function automatic logic f3_legal(
      input logic       w,
      input logic [2:0] f,
      input logic [1:0] a
   );
      logic ok;
      ok = 1'b0;
      case (f)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~a[0];
         F3_W:    ok = (a == 2'b00);
         F3_BU:   ok = ~w;
         F3_HU:   ok = ~w & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Pick the addressed lane out of the fetched word and extend it.
   function automatic logic [31:0] load_ext(
      input logic [2:0]  f,
      input logic [1:0]  a,
      input logic [31:0] word
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{a, 3'b000} +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (f)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_BU:   r = {24'h0, b};
         F3_HU:   r = {16'h0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Merge sub-word store data into the fetched word; SW replaces it all.
   function automatic logic [31:0] store_merge(
      input logic [2:0]  f,
      input logic [1:0]  a,
      input logic [31:0] word,
      input logic [31:0] wd
   );
      logic [31:0] m;
      m = word;
      case (f)
         F3_B: m[{a, 3'b000} +: 8] = wd[7:0];
         F3_H: begin
            if (a[1]) m[31:16] = wd[15:0];
            else      m[15:0]  = wd[15:0];
         end
         default: m = wd;
      endcase
      return m;
   endfunction

   // Classify the incoming request at the accept edge.
   always_comb begin
      acc_ok = f3_legal(bus.we, bus.func3, bus.addr[1:0]);
      acc_sw = bus.we & (bus.func3 == F3_W);
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         func3_q     <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  we_q    <= bus.we;
                  addr_q  <= bus.addr;
                  func3_q <= bus.func3;
                  wdata_q <= bus.wdata;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  rdata_q <= '0;
                  if (!acc_ok) begin
                     state_q <= S_RESP;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (acc_sw) begin
                     state_q     <= S_WRITE;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= {bus.addr[31:2], 2'b00};
                     mem_wdata_q <= bus.wdata;
                  end else begin
                     state_q    <= S_READ;
                     mem_addr_q <= {bus.addr[31:2], 2'b00};
                  end
               end
            end
            S_READ: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_ready) begin
                  if (we_q) begin
                     state_q     <= S_WRITE;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= {addr_q[31:2], 2'b00};
                     mem_wdata_q <= store_merge(func3_q, addr_q[1:0],
                                                mem_rdata, wdata_q);
                  end else begin
                     state_q    <= S_RESP;
                     done_q     <= 1'b1;
                     mem_addr_q <= '0;
                     rdata_q    <= load_ext(func3_q, addr_q[1:0],
                                            mem_rdata);
                  end
               end
            end
            S_WRITE: begin
               state_q     <= S_RESP;
               done_q      <= 1'b1;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
            S_RESP: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
